decade_down_counter: RTL

//   Cascadable multi-digit BCD down-counter: the count-down companion to the

---
 rtl/decade_down_counter_pkg.sv | 16 +
 rtl/decade_down_counter_digit.sv | 26 ++
 rtl/decade_down_counter.sv | 37 +++
 3 files changed

// File: rtl/decade_down_counter_pkg.sv
// Shared BCD constants and helpers for the decade counter family.
package decade_down_counter_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Non-decimal nibbles (A..F) clamp to the largest digit.
    function automatic logic [3:0] bcd_sat(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] v);
        return (v == BCD_ZERO) ? BCD_MAX : v - 4'd1;
    endfunction

endpackage

// File: rtl/decade_down_counter_digit.sv
// One BCD digit of the down counter with its borrow output.
module bcd_down_digit
    import decade_down_counter_pkg::*;
(
    input  logic       x,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] din,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bout_d
);

    always_ff @(posedge x) begin
        if (!reset) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= bcd_sat(din);
        end else if (bin) begin
            q <= bcd_dec(q);
        end
    end

    assign bout_d = bin & (q == BCD_ZERO);

endmodule

// File: rtl/decade_down_counter.sv
// Cascadable multi-digit BCD down counter with preset load.
module decade_down_counter
    import decade_down_counter_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  x,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   z,
    output logic                  zero,
    output logic                  bout
);

    logic [DIGITS:0] borrow;

    assign borrow[0] = en;

    // Borrow ripples upward: a digit steps only when all below are zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_down_digit u_digit (
            .x      (x),
            .reset  (reset),
            .load   (load),
            .din    (d[4*i +: 4]),
            .bin    (borrow[i]),
            .q      (z[4*i +: 4]),
            .bout_d (borrow[i+1])
        );
    end

    assign zero = (z == '0);
    assign bout = borrow[DIGITS] & ~load;

endmodule
